// File: rtl/mdu_pkg.sv
// Shared opcode encodings, FSM states and decode helpers for the multiply/divide unit.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_e;

    localparam int CNT_W = 4;

    // Only the four arithmetic opcodes (0..3) may start a multi-cycle operation.
    function automatic logic is_muldiv(input logic [2:0] op);
        return ~op[2];
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return ~op[2] & op[1];
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational datapath: produces the HI/LO result of mult/multu/div/divu for the latched operands.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic [31:0] hi_nx,
    output logic [31:0] lo_nx,
    output logic        div0
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        signed_div;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] divisor;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] quo;
    logic [31:0] rem;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed division goes through magnitudes so 0x80000000 / -1 wraps to 0x80000000 without overflow.
    assign signed_div = (op == MDU_DIV);
    assign mag_a      = (signed_div && a[31]) ? (32'd0 - a) : a;
    assign mag_b      = (signed_div && b[31]) ? (32'd0 - b) : b;
    assign div0       = is_div(op) && (b == 32'd0);
    assign divisor    = div0 ? 32'd1 : mag_b;
    assign uq         = mag_a / divisor;
    assign ur         = mag_a % divisor;
    assign quo        = (signed_div && (a[31] ^ b[31])) ? (32'd0 - uq) : uq;
    assign rem        = (signed_div && a[31]) ? (32'd0 - ur) : ur;

    always_comb begin
        hi_nx = 32'd0;
        lo_nx = 32'd0;
        case (op)
            MDU_MULT:           {hi_nx, lo_nx} = prod_s;
            MDU_MULTU:          {hi_nx, lo_nx} = prod_u;
            MDU_DIV, MDU_DIVU: begin
                hi_nx = rem;
                lo_nx = quo;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit: IDLE/RUN sequencer, cycle counter and the architectural HI/LO registers.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic        MoveWe,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);

    mdu_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      hi_pend;
    logic [31:0]      lo_pend;
    logic             commit;
    logic [31:0]      hi_nx;
    logic [31:0]      lo_nx;
    logic             div0;

    mdu_calc u_calc (
        .a     (A),
        .b     (B),
        .op    (MDUOp),
        .hi_nx (hi_nx),
        .lo_nx (lo_nx),
        .div0  (div0)
    );

    // The result is captured at Start and only committed on the last Busy edge, so reset discards it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            Busy    <= 1'b0;
            HI      <= 32'd0;
            LO      <= 32'd0;
            hi_pend <= 32'd0;
            lo_pend <= 32'd0;
            commit  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start && is_muldiv(MDUOp)) begin
                        state   <= RUN;
                        Busy    <= 1'b1;
                        cnt     <= is_div(MDUOp) ? DIV_CNT : MULT_CNT;
                        hi_pend <= hi_nx;
                        lo_pend <= lo_nx;
                        commit  <= ~div0;
                    end else if (!Start && MoveWe) begin
                        if (MDUOp == MDU_MTHI) begin
                            HI <= A;
                        end else if (MDUOp == MDU_MTLO) begin
                            LO <= A;
                        end
                    end
                end
                RUN: begin
                    if (cnt == CNT_W'(1)) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                        cnt   <= '0;
                        if (commit) begin
                            HI <= hi_pend;
                            LO <= lo_pend;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: directed and random requests checked against an arithmetic reference model.
module tb_mdu_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Start = 1'b0;
    logic        MoveWe = 1'b0;
    logic [2:0]  MDUOp = 3'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
        int          len;
        bit          is_op;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          busy_run = 0;
    int          m_busy = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk    (clk),
        .reset  (reset),
        .Start  (Start),
        .MoveWe (MoveWe),
        .MDUOp  (MDUOp),
        .A      (A),
        .B      (B),
        .Busy   (Busy),
        .HI     (HI),
        .LO     (LO)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference arithmetic straight from the instruction definitions; returns 0 when HI/LO stay unchanged.
    function automatic bit refCompute(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] hi, output logic [31:0] lo);
        longint      sa;
        longint      sb_;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        hi  = 32'd0;
        lo  = 32'd0;
        case (op)
            3'd0: begin
                p = 64'(sa * sb_);
                hi = p[63:32];
                lo = p[31:0];
            end
            3'd1: begin
                p = 64'(a) * 64'(b);
                hi = p[63:32];
                lo = p[31:0];
            end
            3'd2: begin
                if (b == 32'd0) return 1'b0;
                q  = sa / sb_;
                r  = sa % sb_;
                lo = q[31:0];
                hi = r[31:0];
            end
            3'd3: begin
                if (b == 32'd0) return 1'b0;
                lo = a / b;
                hi = a % b;
            end
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    // One cycle of stimulus; the model decides acceptance and queues the expected HI/LO and its due cycle.
    task automatic applyStimulus(input bit s, input bit m, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
        bit          busy_now;
        logic [31:0] rh;
        logic [31:0] rl;
        exp_t        e;
        @(posedge clk);
        #1;
        Start  = s;
        MoveWe = m;
        MDUOp  = op;
        A      = a;
        B      = b;
        busy_now = (m_busy > 0);
        if (busy_now) begin
            m_busy--;
        end else if (s) begin
            if (op < 3'd4) begin
                if (refCompute(op, a, b, rh, rl)) begin
                    m_hi = rh;
                    m_lo = rl;
                end
                e.len   = (op >= 3'd2) ? DIV_N : MULT_N;
                e.hi    = m_hi;
                e.lo    = m_lo;
                e.due   = cyc + 1 + e.len;
                e.is_op = 1'b1;
                sb.push_back(e);
                m_busy = e.len;
            end
        end else if (m && (op == 3'd4 || op == 3'd5)) begin
            if (op == 3'd4) m_hi = a;
            else m_lo = a;
            e.hi    = m_hi;
            e.lo    = m_lo;
            e.due   = cyc + 1;
            e.len   = 0;
            e.is_op = 1'b0;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    endtask

    task automatic doReset();
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("reset_busy", {31'd0, Busy}, 32'd0);
        checkOutput("reset_hi", HI, 32'd0);
        checkOutput("reset_lo", LO, 32'd0);
        sb.delete();
        m_busy = 0;
        m_hi   = 32'd0;
        m_lo   = 32'd0;
        #3;
        reset = 1'b1;
    endtask

    // Monitor: whenever a queued result falls due, compare HI/LO and the length of the Busy window.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                checkOutput("hi", HI, e.hi);
                checkOutput("lo", LO, e.lo);
                if (e.is_op) begin
                    checkOutput("busy_len", busy_run, e.len);
                    checkOutput("busy_drop", {31'd0, Busy}, 32'd0);
                end
            end
            if (Busy) busy_run++;
            else busy_run = 0;
        end else begin
            busy_run = 0;
        end
    end

    initial begin
        #2;
        checkOutput("por_busy", {31'd0, Busy}, 32'd0);
        checkOutput("por_hi", HI, 32'd0);
        checkOutput("por_lo", LO, 32'd0);
        #5;
        reset = 1'b1;

        applyStimulus(1'b1, 1'b0, 3'd0, 32'hFFFF_FFFE, 32'd3);
        idle(MULT_N);
        applyStimulus(1'b1, 1'b0, 3'd1, 32'hFFFF_FFFF, 32'd2);
        idle(MULT_N);
        applyStimulus(1'b1, 1'b0, 3'd2, 32'hFFFF_FFF9, 32'd2);
        idle(DIV_N);
        applyStimulus(1'b1, 1'b0, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(DIV_N);

        applyStimulus(1'b0, 1'b1, 3'd4, 32'h11, 32'd0);
        applyStimulus(1'b0, 1'b1, 3'd5, 32'h22, 32'd0);
        applyStimulus(1'b1, 1'b0, 3'd3, 32'h1234, 32'd0);
        idle(DIV_N);
        applyStimulus(1'b0, 1'b1, 3'd4, 32'hABCD, 32'd0);
        idle(2);

        // Requests while busy are dropped; back-to-back start lands in the first idle cycle.
        applyStimulus(1'b1, 1'b0, 3'd0, 32'd1000, 32'd1000);
        applyStimulus(1'b1, 1'b0, 3'd2, 32'd100, 32'd7);
        applyStimulus(1'b0, 1'b1, 3'd5, 32'hDEAD, 32'd0);
        idle(MULT_N - 2);
        applyStimulus(1'b1, 1'b0, 3'd3, 32'd100, 32'd7);
        idle(DIV_N);
        applyStimulus(1'b1, 1'b1, 3'd1, 32'd9, 32'd9);
        idle(MULT_N);
        applyStimulus(1'b1, 1'b0, 3'd4, 32'h5555, 32'd0);
        applyStimulus(1'b0, 1'b1, 3'd2, 32'h6666, 32'd1);
        idle(2);

        applyStimulus(1'b1, 1'b0, 3'd0, 32'd5, 32'd7);
        idle(2);
        doReset();
        idle(MULT_N + 4);
        checkOutput("post_reset_hi", HI, 32'd0);
        checkOutput("post_reset_lo", LO, 32'd0);

        for (int i = 0; i < 400; i++) begin
            int          r;
            logic [31:0] ra;
            logic [31:0] rb;
            r  = $urandom_range(0, 9);
            ra = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = $urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            applyStimulus(r < 3, r == 3 || r == 4, 3'($urandom_range(0, 7)), ra, rb);
        end
        idle(DIV_N + 3);

        checkOutput("scoreboard_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
